// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared register map, status bit positions and engine state encoding
package sd_spi_pkg;
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} spi_state_e;
endpackage

// File: rtl/sd_spi_shifter.sv
// sd_spi_shifter: mode-0 byte shift engine with per-phase divider and start/busy/done handshake
module sd_spi_shifter
  import sd_spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       tx_data,
  input  logic [DIV_W-1:0] div,
  input  logic             miso,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             mosi,
  output logic [7:0]       rx
);
  spi_state_e       state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx;
  assign busy = state != IDLE;
  // divider is re-latched at every phase start so DIV writes apply from the next phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= LOW;
          cnt     <= '0;
          div_q   <= div;
          bit_cnt <= 3'd7;
          tx      <= tx_data;
          mosi    <= tx_data[7];
        end
        LOW: if (cnt == div_q) begin
          state <= HIGH;
          cnt   <= '0;
          div_q <= div;
          sclk  <= 1'b1;
          rx    <= {rx[6:0], miso};
        end else cnt <= cnt + 1'b1;
        HIGH: if (cnt == div_q) begin
          cnt   <= '0;
          div_q <= div;
          sclk  <= 1'b0;
          if (bit_cnt == 3'd0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state   <= LOW;
            bit_cnt <= bit_cnt - 1'b1;
            tx      <= {tx[6:0], 1'b0};
            mosi    <= tx[6];
          end
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sd_spi_port.sv
// sd_spi_port: CPU-bus SD/SPI host port with legacy bit-bang mode and hardware byte engine
module sd_spi_port
  import sd_spi_pkg::*;
#(
  parameter int CS_COUNT  = 1,
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 124
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          addr,
  input  logic [7:0]          idata,
  input  logic                we_n,
  input  logic                rd_n,
  output logic [7:0]          odata,
  output logic [CS_COUNT-1:0] spi_cs_n,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  logic                spi_miso
);
  logic [CS_COUNT-1:0] cs;
  logic                mode;
  logic [DIV_W-1:0]    div;
  logic                done_f;
  logic                ovr;
  logic [6:0]          sr;
  logic                sclk_l;
  logic                mosi_l;
  logic                rd_q;
  logic                eng_busy;
  logic                eng_done;
  logic                eng_sclk;
  logic                eng_mosi;
  logic [7:0]          eng_rx;
  logic [7:0]          ctrl_rd;
  logic [7:0]          div_rd;
  logic [7:0]          stat_rd;
  logic                wr_data;
  logic                rd_data;
  assign wr_data  = !we_n && addr == ADDR_DATA;
  assign rd_data  = !rd_n && rd_q && addr == ADDR_DATA;
  assign spi_cs_n = ~cs;
  assign spi_sclk = mode ? eng_sclk : sclk_l;
  assign spi_mosi = mode ? eng_mosi : mosi_l;
  sd_spi_shifter #(.DIV_W(DIV_W)) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (wr_data && mode && !eng_busy),
    .tx_data (idata),
    .div     (div),
    .miso    (spi_miso),
    .busy    (eng_busy),
    .done    (eng_done),
    .sclk    (eng_sclk),
    .mosi    (eng_mosi),
    .rx      (eng_rx)
  );
  // bus registers, sticky status and the legacy bit-bang path; status sets win over read clears
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs     <= '0;
      mode   <= 1'b0;
      div    <= DIV_W'(DIV_RESET);
      done_f <= 1'b0;
      ovr    <= 1'b0;
      sr     <= '0;
      sclk_l <= 1'b0;
      mosi_l <= 1'b1;
      rd_q   <= 1'b1;
    end else begin
      rd_q <= rd_n;
      if (!we_n && addr == ADDR_CTRL) begin
        cs <= idata[CS_COUNT-1:0];
        if (!eng_busy) mode <= idata[7];
      end
      if (!we_n && addr == ADDR_DIV) div <= idata[DIV_W-1:0];
      if (mode && rd_data) begin
        done_f <= 1'b0;
        ovr    <= 1'b0;
      end
      if (mode && wr_data && eng_busy) ovr <= 1'b1;
      if (eng_done) done_f <= 1'b1;
      if (!mode && wr_data) begin
        if (sclk_l) sr <= {sr[5:0], spi_miso};
        mosi_l <= idata[7];
        sclk_l <= 1'b0;
      end
      if (!mode && rd_data) sclk_l <= 1'b1;
    end
  end
  // combinational read mux
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CS_COUNT-1:0] = cs;
    ctrl_rd[7] = mode;
    div_rd = '0;
    div_rd[DIV_W-1:0] = div;
    stat_rd = '0;
    stat_rd[STAT_BUSY] = eng_busy;
    stat_rd[STAT_DONE] = done_f;
    stat_rd[STAT_OVR]  = ovr;
    odata = addr == ADDR_CTRL ? ctrl_rd :
            addr == ADDR_DATA ? (mode ? eng_rx : {sr, spi_miso}) :
            addr == ADDR_DIV  ? div_rd : stat_rd;
  end
endmodule

// File: tb/tb_sd_spi_port.sv
// tb_sd_spi_port: register table, legacy sequence and randomized engine transfers vs a bit-stream model
module tb_sd_spi_port;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] idata = 8'h00;
  logic       we_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       spi_miso = 1'b0;
  wire  [7:0] odata;
  wire  [2:0] spi_cs_n;
  wire        spi_sclk;
  wire        spi_mosi;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    logic [2:0] csn;
  } vec_t;
  vec_t tbl[8];

  always #10 clk = ~clk;

  sd_spi_port #(.CS_COUNT(3), .DIV_W(8), .DIV_RESET(124)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .idata    (idata),
    .we_n     (we_n),
    .rd_n     (rd_n),
    .odata    (odata),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; idata = d; we_n = 1'b0;
    @(negedge clk);
    we_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; rd_n = 1'b0;
    #1 d = odata;
    @(negedge clk);
    rd_n = 1'b1;
  endtask

  task automatic rchk(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  // one engine byte; the model expects tx MSB-first on mosi, mb sampled into rx,
  // phase 0 lasting dv+1 clocks and every later phase ndv+1 clocks
  task automatic xfer(input logic [7:0] tx, input logic [7:0] mb, input int dv, input int inj_at,
                      input logic [1:0] inj_a, input logic [7:0] inj_d, input int ndv, input logic [7:0] exp_stat);
    int rises = 0, run = 0, phases = 0, busy_n = 0, bad_len = 0, unstable = 0;
    logic prev = 1'b0, s, m, b, fin = 1'b0, mhi = 1'b0;
    logic [7:0] got = 8'h00;
    spi_miso = mb[7];
    wr(2'd1, tx);
    for (int c = 0; c < 6000 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      if (c == inj_at) begin addr = inj_a; idata = inj_d; we_n = 1'b0; end
      else begin addr = 2'd3; we_n = 1'b1; end
      #1;
      s = spi_sclk; m = spi_mosi;
      b = (c == inj_at) ? 1'b1 : odata[0];
      if (s != prev) begin
        if (run != ((phases == 0) ? dv : ndv) + 1) bad_len++;
        phases++; run = 1;
        if (s) begin got = {got[6:0], m}; mhi = m; rises++; end
      end else run++;
      if (s && m != mhi) unstable++;
      spi_miso = (rises < 8) ? mb[7 - rises] : 1'b0;
      prev = s;
      if (b) busy_n++; else fin = 1'b1;
    end
    addr = 2'd3; we_n = 1'b1;
    check("xfer_completed", fin, 1);
    check("busy_clocks", busy_n, (dv + 1) + 15 * (ndv + 1));
    check("sclk_rises", rises, 8);
    check("sclk_phases", phases, 16);
    check("mosi_stream", got, tx);
    check("phase_len_errors", bad_len, 0);
    check("mosi_changes_high", unstable, 0);
    rchk("stat_after_xfer", 2'd3, exp_stat);
    rchk("rx_data", 2'd1, mb);
    rchk("stat_cleared", 2'd3, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tx, mb, d;
    int dv, seen;
    tbl[0] = '{2'd0, 8'h85, 8'h85, 3'b010};
    tbl[1] = '{2'd0, 8'h07, 8'h07, 3'b000};
    tbl[2] = '{2'd0, 8'h7A, 8'h02, 3'b101};
    tbl[3] = '{2'd2, 8'h00, 8'h00, 3'b101};
    tbl[4] = '{2'd2, 8'hFF, 8'hFF, 3'b101};
    tbl[5] = '{2'd2, 8'h03, 8'h03, 3'b101};
    tbl[6] = '{2'd3, 8'hFF, 8'h00, 3'b101};
    tbl[7] = '{2'd0, 8'h00, 8'h00, 3'b111};
    repeat (3) @(negedge clk);
    #1 check("rst_cs_n", spi_cs_n, 3'b111);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 1);
    reset_n = 1'b1;
    rchk("rst_ctrl", 2'd0, 8'h00);
    rchk("rst_div", 2'd2, 8'd124);
    rchk("rst_stat", 2'd3, 8'h00);
    rchk("rst_data", 2'd1, 8'h00);
    foreach (tbl[i]) begin
      wr(tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d_cs_n", i), spi_cs_n, tbl[i].csn);
      rchk($sformatf("tbl%0d_read", i), tbl[i].a, tbl[i].rd);
    end
    // legacy bit-bang sequence
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h80);
    check("leg_mosi_1", spi_mosi, 1);
    check("leg_sclk_low", spi_sclk, 0);
    @(negedge clk);
    addr = 2'd1; rd_n = 1'b0;
    #1 check("leg_sclk_before_edge", spi_sclk, 0);
    @(negedge clk);
    check("leg_sclk_after_read", spi_sclk, 1);
    rd_n = 1'b1;
    spi_miso = 1'b1;
    wr(2'd1, 8'h00);
    check("leg_sclk_fall", spi_sclk, 0);
    check("leg_mosi_0", spi_mosi, 0);
    spi_miso = 1'b0;
    rchk("leg_sr_bit0", 2'd1, 8'h02);
    // engine byte from the plan
    wr(2'd0, 8'h81);
    wr(2'd2, 8'd1);
    xfer(8'hA5, 8'h3C, 1, -1, 2'd0, 8'h00, 1, 8'h02);
    // randomized transfers
    for (int k = 0; k < 12; k++) begin
      dv = int'($urandom_range(0, 3));
      tx = 8'($urandom);
      mb = 8'($urandom);
      wr(2'd2, 8'(dv));
      xfer(tx, mb, dv, -1, 2'd0, 8'h00, dv, 8'h02);
    end
    // DIV=0 boundary
    wr(2'd2, 8'd0);
    xfer(8'h5A, 8'hC3, 0, -1, 2'd0, 8'h00, 0, 8'h02);
    // overrun: DATA write at clock 5 is ignored
    wr(2'd2, 8'd1);
    xfer(8'hA5, 8'h96, 1, 5, 2'd1, 8'hFF, 1, 8'h06);
    // CTRL write while busy: CS follows, MODE stays
    wr(2'd0, 8'h85);
    check("cs3_cs_n", spi_cs_n, 3'b010);
    xfer(8'h3C, 8'h81, 1, 5, 2'd0, 8'h01, 1, 8'h02);
    check("ctrl_busy_cs_n", spi_cs_n, 3'b110);
    rchk("ctrl_busy_mode_kept", 2'd0, 8'h81);
    // DIV 255 rewritten to 3 inside the first phase
    wr(2'd2, 8'd255);
    xfer(8'hE7, 8'h18, 255, 10, 2'd2, 8'd3, 3, 8'h02);
    // reset during bit 4 of a transfer
    wr(2'd0, 8'h85);
    wr(2'd2, 8'd2);
    wr(2'd1, 8'h00);
    addr = 2'd3;
    seen = 0;
    for (int c = 0; c < 200 && seen < 4; c++) begin
      @(negedge clk);
      #1 if (spi_sclk && !dut.u_shifter.sclk) seen = seen;
      if (spi_sclk) begin
        seen++;
        while (spi_sclk && seen < 4) @(negedge clk);
      end
    end
    check("reached_bit4", seen, 4);
    check("pre_reset_mosi", spi_mosi, 0);
    reset_n = 1'b0;
    #1 check("mid_rst_cs_n", spi_cs_n, 3'b111);
    check("mid_rst_sclk", spi_sclk, 0);
    check("mid_rst_mosi", spi_mosi, 1);
    check("mid_rst_stat", odata, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    rchk("post_rst_div", 2'd2, 8'd124);
    rchk("post_rst_ctrl", 2'd0, 8'h00);
    rchk("post_rst_stat", 2'd3, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
